// File: rtl/pixel_fb_writer_if.sv
// Pixel/clear/RAM-write bundle between the screen drawers and pixel_fb_writer.
// The drawer side uses the master modport; the writer block uses the slave modport.
interface pixel_fb_writer_if;
  logic        plot_in;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  c_in;
  logic        ready_out;
  logic        clear_req;
  logic [2:0]  clear_colour;
  logic        clear_done;
  logic        busy;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic [7:0]  oob_count;

  modport slave (
    input  plot_in, x_in, y_in, c_in, clear_req, clear_colour,
    output ready_out, clear_done, busy, mem_addr, mem_data, mem_we, oob_count
  );

  modport master (
    output plot_in, x_in, y_in, c_in, clear_req, clear_colour,
    input  ready_out, clear_done, busy, mem_addr, mem_data, mem_we, oob_count
  );
endinterface

// File: rtl/pixel_fb_writer.sv
// pixel_fb_writer: queues (x, y, colour) pixel writes in a small FIFO and turns
// them into registered frame-buffer RAM writes at y*WIDTH + x, one per cycle.
// A clear-screen sequencer fills the whole frame with one colour on request.
// Optional feature macro: FB_BOUNDS_CHECK_EN drops and counts out-of-range pixels.
module pixel_fb_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  pixel_fb_writer_if.slave  fb
);

  localparam int           AW        = $clog2(FIFO_DEPTH);
  localparam int           PIX_N     = WIDTH * HEIGHT;
  localparam logic [14:0]  LAST_ADDR = 15'(PIX_N - 1);
  localparam logic [AW:0]  DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t      state_q, state_d;

  // FIFO entry layout: {y[6:0], x[7:0], colour[2:0]}
  logic [17:0] fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic        clear_pending_q, clear_pending_d;
  logic [2:0]  clear_colour_q, clear_colour_d;
  logic [14:0] clr_addr_q, clr_addr_d;
  logic        last_wr_q, last_wr_d;
  logic        clear_done_q, clear_done_d;

  logic        mem_we_q, mem_we_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [2:0]  mem_data_q, mem_data_d;

  logic        fifo_full, fifo_empty, ready;
  logic        accept, in_range, push, pop;
  logic [17:0] head;
  logic [6:0]  head_y;
  logic [7:0]  head_x;
  logic [2:0]  head_c;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  // ready depends only on registered state, so the handshake uses pre-edge values
  assign ready      = !fifo_full && !clear_pending_q && (state_q == S_RUN);
  assign accept     = fb.plot_in && ready;
  assign push       = accept && in_range;
  assign pop        = (state_q == S_RUN) && !fifo_empty;

  assign head   = fifo_mem_q[rd_ptr_q];
  assign head_y = head[17:11];
  assign head_x = head[10:3];
  assign head_c = head[2:0];

`ifdef FB_BOUNDS_CHECK_EN
  logic [7:0] oob_q, oob_d;

  assign in_range = (32'(fb.x_in) < 32'(WIDTH)) && (32'(fb.y_in) < 32'(HEIGHT));

  // Saturating count of handshaken pixels that fell outside the frame
  always_comb begin
    oob_d = oob_q;
    if (accept && !in_range && (oob_q != 8'hFF)) oob_d = oob_q + 8'd1;
  end

  // Out-of-range counter register
  always_ff @(posedge clk) begin
    if (!resetn) oob_q <= 8'd0;
    else         oob_q <= oob_d;
  end

  assign fb.oob_count = oob_q;
`else
  assign in_range     = 1'b1;
  assign fb.oob_count = 8'd0;
`endif

  // FIFO pointer and occupancy update; simultaneous push and pop keep occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear request capture; a request while one is pending or running is ignored
  always_comb begin
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    if (clear_pending_q) begin
      if (last_wr_q) clear_pending_d = 1'b0;
    end else if (fb.clear_req) begin
      clear_pending_d = 1'b1;
      clear_colour_d  = fb.clear_colour;
    end
    clear_done_d = last_wr_q;
  end

  // FSM next state and RAM write port: drain FIFO in RUN, sweep frame in CLEAR
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    last_wr_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pop) begin
          mem_we_d   = 1'b1;
          mem_addr_d = 15'(32'(head_y) * 32'(WIDTH) + 32'(head_x));
          mem_data_d = head_c;
        end else if (clear_pending_q && !mem_we_q) begin
          // FIFO drained and last pixel write retired: start the fill
          state_d    = S_CLEAR;
          clr_addr_d = 15'd0;
        end
      end
      S_CLEAR: begin
        mem_we_d   = 1'b1;
        mem_addr_d = clr_addr_q;
        mem_data_d = clear_colour_q;
        if (clr_addr_q == LAST_ADDR) begin
          state_d   = S_RUN;
          last_wr_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 15'd1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {fb.y_in, fb.x_in, fb.c_in};
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= S_RUN;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= 3'd0;
      clr_addr_q      <= 15'd0;
      last_wr_q       <= 1'b0;
      clear_done_q    <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= 15'd0;
      mem_data_q      <= 3'd0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      clr_addr_q      <= clr_addr_d;
      last_wr_q       <= last_wr_d;
      clear_done_q    <= clear_done_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
    end
  end

  assign fb.ready_out  = ready;
  assign fb.busy       = !fifo_empty || clear_pending_q || (state_q == S_CLEAR);
  assign fb.clear_done = clear_done_q;
  assign fb.mem_we     = mem_we_q;
  assign fb.mem_addr   = mem_addr_q;
  assign fb.mem_data   = mem_data_q;

endmodule

// File: doc/pixel_fb_writer.md
# pixel_fb_writer

Pixel-stream sink that sits between the screen drawers (title screen, sprites, score) and the 160x120x3-bit frame buffer RAM. It accepts `(x, y, colour, plot)` writes through a small FIFO with backpressure, computes the linear RAM address `y*WIDTH + x`, and issues one registered RAM write per cycle. It also provides a hardware clear-screen sequencer, so drawers do not sweep the whole frame themselves.

## Interface
Parameters:
- `WIDTH`, 160: pixels per row; also the address multiplier.
- `HEIGHT`, 120: rows per frame.
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `plot_in`  in  1: pixel valid.
- `x_in`  in  8: pixel column.
- `y_in`  in  7: pixel row.
- `c_in`  in  3: pixel colour.
- `ready_out`  out  1: the block can accept a pixel this cycle.
- `clear_req`  in  1: one-cycle pulse that requests a full-screen fill.
- `clear_colour`  in  3: fill colour, captured together with `clear_req`.
- `clear_done`  out  1: one-cycle pulse after the last fill write.
- `busy`  out  1: high when the FIFO is non-empty, a clear is pending, or the block is in CLEAR.
- `mem_addr`  out  15: RAM write address (registered).
- `mem_data`  out  3: RAM write data (registered).
- `mem_we`  out  1: RAM write enable (registered, one cycle per write).
- `oob_count`  out  8: count of discarded out-of-range pixels, saturating at 255.

## Operation
- A pixel is accepted on an edge where `plot_in && ready_out`.
- `ready_out = !fifo_full && !clear_pending && state==RUN`. This is combinational from registered state only.
- Bounds check: a pixel with `x_in >= WIDTH` or `y_in >= HEIGHT` is handshaken but not written to the FIFO, and `oob_count` increments. Under `FB_BOUNDS_CHECK_EN` only.
- Address arithmetic: `mem_addr = y*WIDTH + x`, computed at full width, then 15 bits. For the defaults the maximum is 19199 (y=119, x=159).
- FSM states:
  - RUN: each cycle the FIFO is non-empty, pop one entry and register `mem_addr`/`mem_data` with `mem_we=1`. Otherwise `mem_we=0`.
  - RUN to CLEAR: taken when `clear_pending` and the FIFO is empty and no write is in flight.
  - CLEAR: counter `clr_addr` runs 0 to `WIDTH*HEIGHT-1`, one write per cycle with `mem_data=clear_colour_q`.
  - CLEAR to RUN: after the write at `WIDTH*HEIGHT-1`. `clear_done` pulses in the cycle that follows and `clear_pending` clears.
- `clear_req` sets `clear_pending` and latches `clear_colour_q`.
  - If `clear_req` arrives while already pending or in CLEAR, it is ignored and the first colour is kept.
- Pixels already in the FIFO when `clear_req` arrives are written before the clear starts. New pixels are refused until the clear completes.
- Same-cycle `clear_req` and an accepted pixel: the pixel is queued, because the handshake uses the pre-edge `ready_out`.
- Push and pop in the same cycle leave the FIFO occupancy unchanged. When full, no push is possible because `ready_out` is low.

## Timing
- Reset values:
  - `mem_we=0`, `mem_addr=0`, `mem_data=0`
  - `clear_done=0`, `busy=0`, `oob_count=0`
  - `ready_out=1`; FSM in RUN
  - FIFO empty, `clear_pending=0`
- Reset mid-clear or with a non-empty FIFO aborts immediately. No `clear_done` pulse is produced and the FIFO contents are lost.
- Write latency, pixel accepted at edge N with the FIFO empty: pop at N+1, so `mem_we`/`mem_addr`/`mem_data` are valid in the cycle after edge N+1. Each extra queued entry adds one cycle.
- Throughput is one pixel per cycle sustained.
- Clear duration: `WIDTH*HEIGHT` cycles of `mem_we=1`, so 19200 for the defaults. `clear_done` rises one cycle after the final write.

## Configuration
- `FB_BOUNDS_CHECK_EN` defined: out-of-range pixels are dropped and counted in `oob_count`.
- `FB_BOUNDS_CHECK_EN` undefined:
  - No range check; every accepted pixel is written.
  - The address is the raw `y*WIDTH + x`, truncated to 15 bits.
  - `oob_count` is tied to 0.

## Test plan
- Single pixel: after reset, plot (x=5, y=3, c=3) -> one `mem_we` pulse with `mem_addr=485`, `mem_data=3`, two edges after acceptance. `busy` then returns to 0.
- Burst backpressure: hold `plot_in` for 8 consecutive pixels (x=0..7, y=0) -> all 8 are written in order at addresses 0..7. `ready_out` never drops, because push and pop happen in the same cycle.
- Full FIFO: stall-free input of 4 pixels while a clear is pending is refused. Then queue 4 pixels followed by `clear_req` -> those 4 writes precede the first fill write at address 0.
- Clear: `clear_req` with `clear_colour=6` -> 19200 writes, addresses 0..19199, all data 6. `clear_done` pulses once, and `ready_out` returns to 1 on the same cycle.
- Bounds: plot (x=160, y=10) and (x=0, y=120) -> no `mem_we` and `oob_count=2`. With 300 bad pixels, `oob_count` saturates at 255 (macro defined).
- Reset mid-clear: assert `resetn=0` at fill address 1000 -> the next cycle shows all outputs at reset values, no `clear_done`, and a fresh pixel is accepted afterwards.
